// File: rtl/decoder_scan_ctrl.sv
// Address sequencer for an n-to-2^n decoder: dwell/blank timed scan, single or continuous.
// Optional `SCAN_SKIP_MASK_EN adds skip_mask to leave chosen addresses undriven.
module decoder_scan_ctrl #(
    parameter int N     = 4,
    parameter int DWELL = 4,
    parameter int BLANK = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic                cont,
`ifdef SCAN_SKIP_MASK_EN
    input  logic [(1<<N)-1:0]   skip_mask,
`endif
    output logic [N-1:0]        w,
    output logic                en,
    output logic                busy,
    output logic                done
);

    localparam int A    = 1 << N;
    localparam int MAXV = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW   = $clog2(MAXV + 1);

    localparam logic [CW-1:0] DW_LD = CW'(DWELL - 1);
    localparam logic [CW-1:0] BL_LD = CW'((BLANK > 0) ? BLANK - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    w_q, w_d;
    logic [N-1:0]    nxt_q, nxt_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            empty_q, empty_d;
    logic            en_q, en_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            fin;

    logic [A-1:0]    mask;
    logic            up_hit, lo_hit;
    logic [N-1:0]    up_addr, lo_addr;

`ifdef SCAN_SKIP_MASK_EN
    assign mask = skip_mask;
`else
    assign mask = '0;
`endif

    // Lowest unmasked address above w_q, and lowest unmasked overall.
    always_comb begin
        up_hit  = 1'b0;
        up_addr = '0;
        lo_hit  = 1'b0;
        lo_addr = '0;
        for (int i = A - 1; i >= 0; i--) begin
            if (!mask[i]) begin
                lo_hit  = 1'b1;
                lo_addr = N'(i);
                if (i > int'(w_q)) begin
                    up_hit  = 1'b1;
                    up_addr = N'(i);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            w_q     <= '0;
            nxt_q   <= '0;
            cnt_q   <= '0;
            empty_q <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            nxt_q   <= nxt_d;
            cnt_q   <= cnt_d;
            empty_q <= empty_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        nxt_d   = nxt_q;
        cnt_d   = cnt_q;
        empty_d = empty_q;
        fin     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                w_d     = '0;
                cnt_d   = '0;
                empty_d = 1'b0;
                if (start && !stop) begin
                    if (lo_hit) begin
                        state_d = S_DRIVE;
                        w_d     = lo_addr;
                        cnt_d   = DW_LD;
                    end else begin
                        // Nothing to drive: one busy cycle, then complete.
                        state_d = S_GAP;
                        empty_d = 1'b1;
                    end
                end
            end
            S_DRIVE: begin
                if (stop) begin
                    state_d = S_IDLE;
                    w_d     = '0;
                    cnt_d   = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (up_hit || (cont && lo_hit)) begin
                    nxt_d = up_hit ? up_addr : lo_addr;
                    if (BLANK > 0) begin
                        state_d = S_GAP;
                        cnt_d   = BL_LD;
                    end else begin
                        w_d   = nxt_d;
                        cnt_d = DW_LD;
                    end
                end else begin
                    state_d = S_IDLE;
                    w_d     = '0;
                    cnt_d   = '0;
                    fin     = 1'b1;
                end
            end
            S_GAP: begin
                if (stop) begin
                    state_d = S_IDLE;
                    w_d     = '0;
                    cnt_d   = '0;
                    empty_d = 1'b0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (empty_q) begin
                    state_d = S_IDLE;
                    w_d     = '0;
                    empty_d = 1'b0;
                    fin     = 1'b1;
                end else begin
                    state_d = S_DRIVE;
                    w_d     = nxt_q;
                    cnt_d   = DW_LD;
                end
            end
            default: begin
                state_d = S_IDLE;
                w_d     = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        en_d   = (state_d == S_DRIVE);
        busy_d = (state_d != S_IDLE);
        done_d = fin;
    end

    assign w    = w_q;
    assign en   = en_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Bench for decoder_scan_ctrl: queue-based scan model checked every cycle,
// plus literal checks of the documented sequences.
module tb_decoder_scan_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic sa, pa, ca, sb, pb, cb;
    logic [1:0] wa, wb;
    logic ena, busya, donea, enb, busyb, doneb;
`ifdef SCAN_SKIP_MASK_EN
    logic [3:0] ma, mb;
`endif

    int n_chk = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    // entry = {w[1:0], en, busy, done}
    logic [4:0] qa[$];
    logic [4:0] qb[$];

    always #5 clk = ~clk;

    decoder_scan_ctrl #(.N(2), .DWELL(2), .BLANK(1)) u_a (
        .clk(clk), .rst(rst), .start(sa), .stop(pa), .cont(ca),
`ifdef SCAN_SKIP_MASK_EN
        .skip_mask(ma),
`endif
        .w(wa), .en(ena), .busy(busya), .done(donea)
    );

    decoder_scan_ctrl #(.N(2), .DWELL(1), .BLANK(0)) u_b (
        .clk(clk), .rst(rst), .start(sb), .stop(pb), .cont(cb),
`ifdef SCAN_SKIP_MASK_EN
        .skip_mask(mb),
`endif
        .w(wb), .en(enb), .busy(busyb), .done(doneb)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected output stream of one start: per driven address DWELL enabled
    // cycles, BLANK gap cycles between driven addresses (and before a wrap),
    // per = number of continuous periods before the final one, then done.
    task automatic push_scan(input bit sel, input int d, input int bl,
                             input int per, input logic [3:0] m);
        int drv[$];
        logic [4:0] e[$];
        for (int a = 0; a < 4; a++)
            if (!m[a]) drv.push_back(a);
        if (drv.size() == 0) begin
            e.push_back(5'b00010);
        end else begin
            for (int p = 0; p <= per; p++)
                for (int k = 0; k < drv.size(); k++) begin
                    for (int j = 0; j < d; j++)
                        e.push_back({2'(drv[k]), 3'b110});
                    if (k < drv.size() - 1 || p < per)
                        for (int j = 0; j < bl; j++)
                            e.push_back({2'(drv[k]), 3'b010});
                end
        end
        e.push_back(5'b00001);
        foreach (e[i]) begin
            if (sel) qb.push_back(e[i]);
            else qa.push_back(e[i]);
        end
    endtask

    task automatic start_scan(input bit sel, input int d, input int bl,
                              input int per, input logic [3:0] m);
        @(posedge clk);
        #1;
        if (sel) qb.push_back(5'b0);
        else qa.push_back(5'b0);
        push_scan(sel, d, bl, per, m);
        if (sel) sb = 1'b1;
        else sa = 1'b1;
        @(posedge clk);
        #1;
        sa = 1'b0;
        sb = 1'b0;
    endtask

    task automatic trunc_a();
        while (qa.size() > 1) void'(qa.pop_back());
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            if (qa.size() == 0 && qb.size() == 0) break;
            @(posedge clk);
        end
        chk("drain_timeout", qa.size() + qb.size(), 0);
    endtask

    always @(negedge clk) begin
        logic [4:0] ea, eb;
        if (chk_on) begin
            ea = (qa.size() != 0) ? qa.pop_front() : 5'b0;
            eb = (qb.size() != 0) ? qb.pop_front() : 5'b0;
            chk("trace_a", {wa, ena, busya, donea}, ea);
            chk("trace_b", {wb, enb, busyb, doneb}, eb);
        end
    end

    initial begin
        int lw[11] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3};
        int le[11] = '{1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1};
        rst = 1'b1;
        sa = 1'b1;
        pa = 1'b0;
        ca = 1'b0;
        sb = 1'b1;
        pb = 1'b0;
        cb = 1'b0;
`ifdef SCAN_SKIP_MASK_EN
        ma = 4'b0;
        mb = 4'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk_on = 1'b1;
        chk("reset_outs_a", {wa, ena, busya, donea}, 0);
        chk("reset_outs_b", {wb, enb, busyb, doneb}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sa = 1'b0;
        sb = 1'b0;
        @(posedge clk);

        // single scan with literal sequence
        start_scan(0, 2, 1, 0, 4'b0);
        chk("single_model_len", qa.size(), 12);
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            if (i < 11) begin
                chk("single_w", wa, lw[i]);
                chk("single_en", ena, le[i]);
                chk("single_busy", busya, 1);
            end else if (i == 11) begin
                chk("single_done", {wa, ena, busya, donea}, 5'b00001);
            end else begin
                chk("single_done_off", donea, 0);
            end
        end
        wait_idle();

        // start while busy is ignored
        start_scan(0, 2, 1, 0, 4'b0);
        repeat (3) @(posedge clk);
        #1;
        sa = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        sa = 1'b0;
        wait_idle();

        // abort during the first (2,1) cycle, then restart
        start_scan(0, 2, 1, 0, 4'b0);
        repeat (6) @(posedge clk);
        #1;
        pa = 1'b1;
        trunc_a();
        @(negedge clk);
        chk("abort_at_w2", {wa, ena}, 3'b101);
        @(posedge clk);
        #1;
        pa = 1'b0;
        @(negedge clk);
        chk("abort_idle", {wa, ena, busya, donea}, 0);
        wait_idle();
        start_scan(0, 2, 1, 0, 4'b0);
        wait_idle();

        // reset mid-scan at w=1
        start_scan(0, 2, 1, 0, 4'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        trunc_a();
        @(negedge clk);
        chk("rst_at_w1", {wa, ena}, 3'b011);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_outs", {wa, ena, busya, donea}, 0);
        wait_idle();

        // start and stop together in IDLE
        @(posedge clk);
        #1;
        sa = 1'b1;
        pa = 1'b1;
        @(posedge clk);
        #1;
        sa = 1'b0;
        pa = 1'b0;
        @(negedge clk);
        chk("start_stop_idle", busya, 0);
        wait_idle();

        // continuous: three full periods, then a final scan
        ca = 1'b1;
        start_scan(0, 2, 1, 3, 4'b0);
        chk("cont_model_len", qa.size(), 48);
        for (int i = 1; i <= 13; i++) begin
            @(negedge clk);
            if (i == 11) chk("cont_last", {wa, ena}, 3'b111);
            if (i == 12) chk("cont_gap", {wa, ena, busya}, 4'b1101);
            if (i == 13) chk("cont_wrap", {wa, ena}, 3'b001);
        end
        repeat (27) @(posedge clk);
        #1;
        ca = 1'b0;
        wait_idle();

        // back-to-back addresses, BLANK=0 DWELL=1
        start_scan(1, 1, 0, 0, 4'b0);
        chk("b2b_model_len", qb.size(), 5);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i < 4) chk("b2b_drive", {wb, enb}, {2'(i), 1'b1});
            else chk("b2b_done", {wb, enb, busyb, doneb}, 5'b00001);
        end
        wait_idle();

`ifdef SCAN_SKIP_MASK_EN
        ma = 4'b0101;
        start_scan(0, 2, 1, 0, 4'b0101);
        chk("skip_model_len", qa.size(), 6);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            case (i)
                0, 1: chk("skip_w1", {wa, ena}, 3'b011);
                2: chk("skip_gap", {wa, ena, busya}, 4'b0101);
                3, 4: chk("skip_w3", {wa, ena}, 3'b111);
                default: chk("skip_done", {wa, ena, busya, donea}, 5'b00001);
            endcase
        end
        wait_idle();
        ma = 4'b1111;
        ca = 1'b1;
        start_scan(0, 2, 1, 0, 4'b1111);
        @(negedge clk);
        chk("allmask_busy", {ena, busya, donea}, 3'b010);
        @(negedge clk);
        chk("allmask_done", {ena, busya, donea}, 3'b001);
        @(negedge clk);
        chk("allmask_idle", {ena, busya, donea}, 3'b000);
        ca = 1'b0;
        ma = 4'b0;
        wait_idle();
`endif

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
